// File: rtl/brush_cursor_ctrl.sv
// brush_cursor_ctrl: cursor motion and brush stamping engine
// for the paint design.
//
// Moves a square cursor from four active-low buttons with
// diagonal motion and hold-to-accelerate stepping, clamps it to
// the screen, and when painting is enabled streams every pixel
// of the brush square through a valid/ready write port.
//
// Ports:
//   CLOCK_50            clock
//   reset               synchronous, active-low
//   up_n/down_n/
//   left_n/right_n      async buttons, active-low
//   size_sel            requested brush size
//   paint_en            stamping enable
//   wr_ready            frame buffer accepts a beat
//   cursor_x/cursor_y   top-left corner of the cursor
//   size_eff            effective brush size
//   wr_valid/wr_x/wr_y  write beat
//   busy                stamp engine active
//   stamp_done          pulse after the last beat
module brush_cursor_ctrl #(
  parameter int W_RES    = 640,
  parameter int H_RES    = 480,
  parameter int COORD_W  = 11,
  parameter int DIVISOR  = 2000000,
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 8,
  parameter int MAX_SIZE = 32,
  parameter int SIZE_W   = 6
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               up_n,
  input  logic               down_n,
  input  logic               left_n,
  input  logic               right_n,
  input  logic [SIZE_W-1:0]  size_sel,
  input  logic               paint_en,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic [SIZE_W-1:0]  size_eff,
  output logic               wr_valid,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               busy,
  output logic               stamp_done
);

  localparam int CNT_W = (DIVISOR > 2) ?
                         $clog2(DIVISOR) : 1;

  localparam logic [SIZE_W-1:0] SZ_MAX =
    SIZE_W'(MAX_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAMP,
    S_DONE
  } state_t;

  function automatic logic [SIZE_W-1:0] size_of(
    input logic [SIZE_W-1:0] s
  );
    logic [SIZE_W-1:0] r;
    r = s;
    if (s == '0) r = SIZE_W'(1);
    else if (s > SZ_MAX) r = SZ_MAX;
    return r;
  endfunction

  // Button synchroniser, packed {up, down, left, right}
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic [3:0] raw_n;
  logic [3:0] pr;

  assign raw_n = {up_n, down_n, left_n, right_n};
  assign pr    = ~sync_q;

  // Cursor / tick / step state
  logic [SIZE_W-1:0]  size_q,  size_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [COORD_W-1:0] x_q,     x_d;
  logic [COORD_W-1:0] y_q,     y_d;
  logic [COORD_W-1:0] step_q,  step_d;
  logic               pe_q;
  logic               ev_q,    ev_d;
  logic               req_q,   req_d;
  logic               tick;
  logic               moved;

  // Reset origin, centred for the size requested at reset
  logic [SIZE_W-1:0]  sz0;
  logic [COORD_W-1:0] rst_x;
  logic [COORD_W-1:0] rst_y;

  // Signed scratch for saturating motion
  int nx;
  int ny;
  int lim_x;
  int lim_y;
  int dbl;

  // Stamp engine state
  state_t             state_q, state_d;
  logic               pend_q,  pend_d;
  logic [COORD_W-1:0] ox_q,    ox_d;
  logic [COORD_W-1:0] oy_q,    oy_d;
  logic [SIZE_W-1:0]  sz_q,    sz_d;
  logic [SIZE_W-1:0]  col_q,   col_d;
  logic [SIZE_W-1:0]  row_q,   row_d;
  logic [COORD_W-1:0] wx_q,    wx_d;
  logic [COORD_W-1:0] wy_q,    wy_d;
  logic               beat;

  assign tick   = (cnt_q == CNT_LAST);
  assign size_d = size_of(size_sel);

  always_comb begin
    sz0   = size_of(size_sel);
    rst_x = COORD_W'((W_RES - int'(sz0)) / 2);
    rst_y = COORD_W'((H_RES - int'(sz0)) / 2);
  end

  always_comb begin
    nx    = int'(x_q);
    ny    = int'(y_q);
    lim_x = W_RES - int'(size_q);
    lim_y = H_RES - int'(size_q);

    // pr[1]=left pr[0]=right pr[3]=up pr[2]=down
    if (pr[0] && !pr[1]) nx = nx + int'(step_q);
    else if (pr[1] && !pr[0]) nx = nx - int'(step_q);
    if (pr[2] && !pr[3]) ny = ny + int'(step_q);
    else if (pr[3] && !pr[2]) ny = ny - int'(step_q);

    // Clamp also re-fits the cursor after a size change
    if (nx < 0) nx = 0;
    if (nx > lim_x) nx = lim_x;
    if (ny < 0) ny = 0;
    if (ny > lim_y) ny = lim_y;

    dbl = 2 * int'(step_q);
    if (dbl > STEP_MAX) dbl = STEP_MAX;

    cnt_d  = cnt_q + CNT_W'(1);
    x_d    = x_q;
    y_d    = y_q;
    step_d = step_q;
    if (tick) begin
      cnt_d  = '0;
      x_d    = COORD_W'(nx);
      y_d    = COORD_W'(ny);
      step_d = (|pr) ? COORD_W'(dbl)
                     : COORD_W'(STEP_MIN);
    end

    moved = tick && ((x_d != x_q) || (y_d != y_q));
    ev_d  = moved && paint_en;
    // Motion events are delayed one stage so the
    // request lines up with the already-moved cursor.
    req_d = ev_q || (paint_en && !pe_q);
  end

  assign beat = (state_q == S_STAMP) && wr_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    sz_d    = sz_q;
    col_d   = col_q;
    row_d   = row_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_q || pend_q) begin
          state_d = S_STAMP;
          pend_d  = 1'b0;
          ox_d    = x_q;
          oy_d    = y_q;
          sz_d    = size_q;
          col_d   = '0;
          row_d   = '0;
          wx_d    = x_q;
          wy_d    = y_q;
        end
      end
      S_STAMP: begin
        if (req_q) pend_d = 1'b1;
        if (beat) begin
          if (col_q == sz_q - SIZE_W'(1)) begin
            col_d = '0;
            wx_d  = ox_q;
            if (row_q == sz_q - SIZE_W'(1)) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + SIZE_W'(1);
              wy_d  = wy_q + COORD_W'(1);
            end
          end else begin
            col_d = col_q + SIZE_W'(1);
            wx_d  = wx_q + COORD_W'(1);
          end
        end
      end
      S_DONE: begin
        if (req_q) pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      meta_q  <= '1;
      sync_q  <= '1;
      size_q  <= sz0;
      cnt_q   <= '0;
      x_q     <= rst_x;
      y_q     <= rst_y;
      step_q  <= COORD_W'(STEP_MIN);
      pe_q    <= 1'b0;
      ev_q    <= 1'b0;
      req_q   <= 1'b0;
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      sz_q    <= SIZE_W'(1);
      col_q   <= '0;
      row_q   <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      meta_q  <= raw_n;
      sync_q  <= meta_q;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      pe_q    <= paint_en;
      ev_q    <= ev_d;
      req_q   <= req_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      sz_q    <= sz_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign size_eff   = size_q;
  assign wr_valid   = (state_q == S_STAMP);
  assign wr_x       = wx_q;
  assign wr_y       = wy_q;
  assign busy       = (state_q != S_IDLE);
  assign stamp_done = (state_q == S_DONE);

endmodule

// File: tb/tb_brush_cursor_ctrl.sv
// tb_brush_cursor_ctrl: scoreboard bench for the cursor
// and brush stamping engine.
module tb_brush_cursor_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        up_n     = 1'b1;
  logic        down_n   = 1'b1;
  logic        left_n   = 1'b1;
  logic        right_n  = 1'b1;
  logic [5:0]  size_sel = 6'd8;
  logic        paint_en = 1'b0;
  logic        wr_ready = 1'b1;
  logic [10:0] cursor_x;
  logic [10:0] cursor_y;
  logic [5:0]  size_eff;
  logic        wr_valid;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic        busy;
  logic        stamp_done;

  int          n_cmp  = 0;
  int          n_err  = 0;
  int          ph     = 0;
  int          n_done = 0;
  bit          tog    = 1'b0;
  logic [31:0] sbq[$];
  bit          hold_v = 1'b0;
  logic [31:0] hold_xy = '0;

  always #10 CLOCK_50 = ~CLOCK_50;

  brush_cursor_ctrl #(
    .DIVISOR(4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .up_n      (up_n),
    .down_n    (down_n),
    .left_n    (left_n),
    .right_n   (right_n),
    .size_sel  (size_sel),
    .paint_en  (paint_en),
    .wr_ready  (wr_ready),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .size_eff  (size_eff),
    .wr_valid  (wr_valid),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .busy      (busy),
    .stamp_done(stamp_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xy(input int x,
                                     input int y);
    return {10'd0, 11'(x), 11'(y)};
  endfunction

  task automatic push_sq(input int x, input int y,
                         input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        sbq.push_back(xy(x + c, y + r));
  endtask

  always @(negedge CLOCK_50) begin
    if (stamp_done) n_done++;
    if (hold_v) begin
      chk("hold_valid", 32'(wr_valid), 32'd1);
      chk("hold_xy", xy(wr_x, wr_y), hold_xy);
    end
    if (wr_valid && wr_ready) begin
      chk("beat_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0)
        chk("beat", xy(wr_x, wr_y), sbq.pop_front());
    end
    hold_v  = wr_valid && !wr_ready;
    hold_xy = xy(wr_x, wr_y);
  end

  task automatic clk();
    @(posedge CLOCK_50);
    #1;
    ph++;
    wr_ready = tog ? ~wr_ready : 1'b1;
  endtask

  task automatic wait_tick();
    do clk(); while (ph % 4 != 0);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!(sbq.size() == 0 && !busy) && i < 400) begin
      clk();
      i++;
    end
    chk("stamp_timeout", 32'(sbq.size() == 0 && !busy),
        32'd1);
  endtask

  task automatic do_reset(input logic [5:0] s);
    size_sel = s;
    reset = 1'b0;
    repeat (3) clk();
    reset = 1'b1;
    ph = 0;
  endtask

  initial begin
    do_reset(6'd8);
    chk("rst_x", 32'(cursor_x), 32'd316);
    chk("rst_y", 32'(cursor_y), 32'd236);
    chk("rst_size", 32'(size_eff), 32'd8);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(stamp_done), 32'd0);
    chk("rst_wr", xy(wr_x, wr_y), xy(0, 0));

    // Acceleration
    right_n = 1'b0;
    wait_tick(); chk("acc1", 32'(cursor_x), 32'd317);
    wait_tick(); chk("acc2", 32'(cursor_x), 32'd319);
    wait_tick(); chk("acc3", 32'(cursor_x), 32'd323);
    wait_tick(); chk("acc4", 32'(cursor_x), 32'd331);
    wait_tick(); chk("acc5", 32'(cursor_x), 32'd339);
    chk("acc_y", 32'(cursor_y), 32'd236);
    right_n = 1'b1;
    wait_tick(); chk("rel_x", 32'(cursor_x), 32'd339);
    right_n = 1'b0;
    wait_tick(); chk("restep", 32'(cursor_x), 32'd340);

    // Up and down together cancel
    right_n = 1'b1;
    up_n = 1'b0;
    down_n = 1'b0;
    wait_tick();
    chk("conf_y", 32'(cursor_y), 32'd236);
    chk("conf_x", 32'(cursor_x), 32'd340);
    up_n = 1'b1;
    down_n = 1'b1;

    // Right edge clamp, then size growth re-clamps
    right_n = 1'b0;
    for (int i = 0; i < 60; i++) wait_tick();
    chk("clamp", 32'(cursor_x), 32'd632);
    wait_tick();
    chk("clamp_hold", 32'(cursor_x), 32'd632);
    size_sel = 6'd32;
    wait_tick();
    chk("reclamp", 32'(cursor_x), 32'd608);
    chk("size32", 32'(size_eff), 32'd32);
    right_n = 1'b1;
    size_sel = 6'd40;
    clk();
    chk("size_cap", 32'(size_eff), 32'd32);

    // Stamp on paint enable, then one left tick
    do_reset(6'd8);
    size_sel = 6'd2;
    paint_en = 1'b1;
    push_sq(316, 236, 2);
    wait_done();
    chk("done_rise", 32'(n_done), 32'd1);
    wait_tick();
    push_sq(315, 236, 2);
    left_n = 1'b0;
    wait_tick();
    left_n = 1'b1;
    chk("left_x", 32'(cursor_x), 32'd315);
    wait_done();
    chk("done_left", 32'(n_done), 32'd2);

    // Backpressure; moves during the stamp merge into one
    size_sel = 6'd3;
    tog = 1'b1;
    wait_tick();
    push_sq(315, 237, 3);
    push_sq(315, 243, 3);
    down_n = 1'b0;
    wait_tick();
    wait_tick();
    wait_tick();
    down_n = 1'b1;
    chk("bp_y", 32'(cursor_y), 32'd243);
    wait_done();
    chk("done_pend", 32'(n_done), 32'd4);
    tog = 1'b0;

    // Size 0 gives a single beat
    size_sel = 6'd0;
    wait_tick();
    chk("size0", 32'(size_eff), 32'd1);
    push_sq(315, 242, 1);
    up_n = 1'b0;
    wait_tick();
    up_n = 1'b1;
    wait_done();
    chk("done_one", 32'(n_done), 32'd5);

    // Reset in the middle of a stamp
    size_sel = 6'd8;
    wait_tick();
    push_sq(316, 242, 8);
    right_n = 1'b0;
    wait_tick();
    right_n = 1'b1;
    repeat (5) clk();
    chk("mid_valid", 32'(wr_valid), 32'd1);
    paint_en = 1'b0;
    reset = 1'b0;
    clk();
    sbq.delete();
    chk("mr_valid", 32'(wr_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_x", 32'(cursor_x), 32'd316);
    chk("mr_y", 32'(cursor_y), 32'd236);
    chk("mr_wr", xy(wr_x, wr_y), xy(0, 0));
    reset = 1'b1;
    repeat (3) clk();
    chk("post_valid", 32'(wr_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
